// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single data-memory port between the CPU M-stage
// access and a bus-master device. The CPU has priority; a starvation counter
// hands the device every (STARVE_MAX+1)-th conflict. Read data is steered to the
// requester that owned the port in the previous cycle.
module dm_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [31:0] DM_LAST    = 32'h00002fff
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_byteen,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  input  logic        dev_req,
  input  logic [31:0] dev_addr,
  input  logic [3:0]  dev_byteen,
  input  logic [31:0] dev_wdata,
  output logic        dev_gnt,
  output logic        dev_rvalid,
  output logic [31:0] dev_rdata,
  output logic        dev_err,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DEV  = 2'b10
  } ownerT;

  ownerT            owner;
  logic [CNT_W-1:0] starveCnt;
  logic             rdFlag;

  logic devBad;
  logic devValid;
  logic conflict;
  logic devTurn;
  logic cpuGranted;
  logic devGranted;
  logic grantRead;

  // Qualify the device request and decide this cycle's winner; reset blocks all grants.
  always_comb begin
    devBad     = 1'b0;
    devValid   = 1'b0;
    conflict   = 1'b0;
    devTurn    = 1'b0;
    cpuGranted = 1'b0;
    devGranted = 1'b0;
    grantRead  = 1'b0;

    devBad     = dev_req && ((dev_addr > DM_LAST) || (dev_addr[1:0] != 2'b00));
    devValid   = dev_req && !devBad;
    conflict   = cpu_req && devValid;
    devTurn    = (starveCnt >= CNT_W'(STARVE_MAX));
    cpuGranted = reset && cpu_req && !(conflict && devTurn);
    devGranted = reset && devValid && (!cpu_req || devTurn);
    grantRead  = (cpuGranted && (cpu_byteen == 4'b0000)) ||
                 (devGranted && (dev_byteen == 4'b0000));
  end

  // Requester-facing handshake: stall, grant and reject pulse.
  always_comb begin
    cpu_stall = reset && cpu_req && !cpuGranted;
    dev_gnt   = devGranted;
    dev_err   = reset && devBad;
  end

  // Memory port mux: only the winner drives; the idle port is all zeros so the loser never writes.
  always_comb begin
    mem_addr   = 32'h0;
    mem_byteen = 4'b0000;
    mem_wdata  = 32'h0;
    if (cpuGranted) begin
      mem_addr   = cpu_addr;
      mem_byteen = cpu_byteen;
      mem_wdata  = cpu_wdata;
    end else if (devGranted) begin
      mem_addr   = dev_addr;
      mem_byteen = dev_byteen;
      mem_wdata  = dev_wdata;
    end
  end

  // Owner state machine, starvation counter and registered read flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner     <= OWN_NONE;
      starveCnt <= '0;
      rdFlag    <= 1'b0;
    end else begin
      case (owner)
        OWN_NONE: begin
          if (cpuGranted)      owner <= OWN_CPU;
          else if (devGranted) owner <= OWN_DEV;
          else                 owner <= OWN_NONE;
        end
        default: begin
          if (cpuGranted)      owner <= OWN_CPU;
          else if (devGranted) owner <= OWN_DEV;
          else                 owner <= OWN_NONE;
        end
      endcase

      rdFlag <= grantRead;

      // A conflict not won by the device was lost to the CPU.
      if (devGranted || !dev_req) begin
        starveCnt <= '0;
      end else if (conflict) begin
        starveCnt <= starveCnt + CNT_W'(1);
      end
    end
  end

  // Read return steered by last cycle's owner.
  always_comb begin
    cpu_rdata  = (owner == OWN_CPU) ? mem_rdata : 32'h0;
    dev_rvalid = (owner == OWN_DEV) && rdFlag;
    dev_rdata  = dev_rvalid ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: a byte-enabled synchronous memory, a behavioural
// model of the arbitration rules checked every cycle, and directed literal checks.
module tb_dm_port_arbiter;

  localparam int          STARVE = 4;
  localparam logic [31:0] LAST   = 32'h00002fff;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        dev_req;
  logic [31:0] dev_addr;
  logic [3:0]  dev_byteen;
  logic [31:0] dev_wdata;
  logic        dev_gnt;
  logic        dev_rvalid;
  logic [31:0] dev_rdata;
  logic        dev_err;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic [31:0] memRdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] memArr [0:4095];
  logic [31:0] shadow [0:4095];
  int          prevOwner;   // 0 none, 1 cpu, 2 device
  bit          prevDevRead;
  int          lossCount;
  logic [31:0] expRd;
  bit          started = 1'b0;
  logic [9:0]  stallSeq;

  always #5 clk = ~clk;

  dm_port_arbiter #(.STARVE_MAX(STARVE), .DM_LAST(LAST)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_byteen(cpu_byteen), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dev_req(dev_req), .dev_addr(dev_addr), .dev_byteen(dev_byteen), .dev_wdata(dev_wdata),
    .dev_gnt(dev_gnt), .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata), .dev_err(dev_err),
    .mem_addr(mem_addr), .mem_byteen(mem_byteen), .mem_wdata(mem_wdata), .mem_rdata(memRdata)
  );

  function automatic logic [31:0] initWord(int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hA5000000 | 32'(i));
  endfunction

  // Data memory: 1-cycle synchronous read, byte-enabled write, reloaded during reset.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4096; i++) memArr[i] <= initWord(i);
      memRdata <= 32'hBAD0BAD0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_byteen[b]) memArr[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      memRdata <= memArr[mem_addr[13:2]];
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    prevOwner   = 0;
    prevDevRead = 1'b0;
    lossCount   = 0;
    expRd       = 32'h0;
    for (int i = 0; i < 4096; i++) shadow[i] = initWord(i);
  endtask

  // Model: who should own the port now, what memory must see, and what comes back.
  task automatic compareCycle();
    int          who;
    bit          bad;
    bit          dv;
    logic [31:0] eAddr;
    logic [31:0] eWd;
    logic [3:0]  eBe;
    who = 0;
    dv  = 1'b0;
    bad = reset && dev_req && ((dev_addr > LAST) || (dev_addr[1:0] != 2'b00));
    if (reset) begin
      dv = dev_req && !bad;
      if (cpu_req && dv)  who = (lossCount >= STARVE) ? 2 : 1;
      else if (cpu_req)   who = 1;
      else if (dv)        who = 2;
    end
    eAddr = (who == 1) ? cpu_addr   : (who == 2) ? dev_addr   : 32'h0;
    eBe   = (who == 1) ? cpu_byteen : (who == 2) ? dev_byteen : 4'h0;
    eWd   = (who == 1) ? cpu_wdata  : (who == 2) ? dev_wdata  : 32'h0;

    if (started) begin
      chk("cpu_stall",  32'(cpu_stall),  32'(reset && cpu_req && (who != 1)));
      chk("dev_gnt",    32'(dev_gnt),    32'(who == 2));
      chk("dev_err",    32'(dev_err),    32'(bad));
      chk("mem_addr",   mem_addr,        eAddr);
      chk("mem_byteen", 32'(mem_byteen), 32'(eBe));
      chk("mem_wdata",  mem_wdata,       eWd);
      chk("cpu_rdata",  cpu_rdata,       (prevOwner == 1) ? expRd : 32'h0);
      chk("dev_rvalid", 32'(dev_rvalid), 32'(prevOwner == 2 && prevDevRead));
      chk("dev_rdata",  dev_rdata,       (prevOwner == 2 && prevDevRead) ? expRd : 32'h0);
    end

    if (!reset) begin
      modelReset();
      started = 1'b1;
    end else begin
      expRd = shadow[eAddr[13:2]];
      for (int b = 0; b < 4; b++)
        if (eBe[b]) shadow[eAddr[13:2]][8*b +: 8] = eWd[8*b +: 8];
      prevDevRead = (who == 2) && (dev_byteen == 4'h0);
      if (who == 2 || !dev_req) lossCount = 0;
      else if (cpu_req && dv)   lossCount++;
      prevOwner = who;
    end
  endtask

  // One cycle: inputs change just after the rising edge, outputs checked on the falling edge.
  task automatic drive(bit rst, bit creq, logic [31:0] caddr, logic [3:0] cbe, logic [31:0] cwd,
                       bit dreq, logic [31:0] daddr, logic [3:0] dbe, logic [31:0] dwd);
    @(posedge clk);
    #1;
    reset      = rst;
    cpu_req    = creq;
    cpu_addr   = caddr;
    cpu_byteen = cbe;
    cpu_wdata  = cwd;
    dev_req    = dreq;
    dev_addr   = daddr;
    dev_byteen = dbe;
    dev_wdata  = dwd;
    @(negedge clk);
    compareCycle();
  endtask

  initial begin
    reset = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_byteen = '0; cpu_wdata = '0;
    dev_req = 1'b0; dev_addr = '0; dev_byteen = '0; dev_wdata = '0;

    // Reset with live requests: nothing granted, nothing written.
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    drive(0, 1, 32'h10, 4'h0, 32'h0, 1, 32'h20, 4'hF, 32'h11111111);
    chk("rst_stall",  32'(cpu_stall),  32'h0);
    chk("rst_gnt",    32'(dev_gnt),    32'h0);
    chk("rst_byteen", 32'(mem_byteen), 32'h0);

    // CPU load.
    drive(1, 1, 32'h10, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    chk("cpu_ld_stall", 32'(cpu_stall), 32'h0);
    drive(1, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    chk("cpu_ld_data", cpu_rdata, 32'hDEADBEEF);

    // Device store then read back.
    drive(1, 0, 32'h0, 4'h0, 32'h0, 1, 32'h20, 4'hF, 32'h12345678);
    chk("dev_st_gnt", 32'(dev_gnt),    32'h1);
    chk("dev_st_be",  32'(mem_byteen), 32'hF);
    drive(1, 0, 32'h0, 4'h0, 32'h0, 1, 32'h20, 4'h0, 32'h0);
    chk("dev_ld_gnt", 32'(dev_gnt), 32'h1);
    drive(1, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    chk("dev_ld_rvalid", 32'(dev_rvalid), 32'h1);
    chk("dev_ld_data",   dev_rdata,       32'h12345678);

    // Continuous contention: device wins every fifth cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 32'h40, 4'h0, 32'h0, 1, 32'h24, 4'h0, 32'h0);
      stallSeq[i] = cpu_stall;
    end
    chk("starve_pattern", 32'(stallSeq), 32'h210);

    // CPU half-word store stalled by the device's turn, then lands the next cycle.
    for (int i = 0; i < 4; i++)
      drive(1, 1, 32'h50, 4'h0, 32'h0, 1, 32'h30, 4'hF, 32'hCAFEF00D);
    drive(1, 1, 32'h30, 4'h3, 32'h00001111, 1, 32'h30, 4'hF, 32'hCAFEF00D);
    chk("st_stalled",   32'(cpu_stall),  32'h1);
    chk("st_dev_be",    32'(mem_byteen), 32'hF);
    chk("st_dev_wdata", mem_wdata,       32'hCAFEF00D);
    drive(1, 1, 32'h30, 4'h3, 32'h00001111, 0, 32'h0, 4'h0, 32'h0);
    chk("st_cpu_go", 32'(cpu_stall),  32'h0);
    chk("st_cpu_be", 32'(mem_byteen), 32'h3);
    drive(1, 1, 32'h30, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    drive(1, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    chk("st_merge_rd",  cpu_rdata,  32'hCAFE1111);
    chk("st_merge_mem", memArr[12], 32'hCAFE1111);

    // Rejected device requests and the last legal word.
    drive(1, 1, 32'h10, 4'h0, 32'h0, 1, 32'h3000, 4'h0, 32'h0);
    chk("bad_hi_err",   32'(dev_err),   32'h1);
    chk("bad_hi_gnt",   32'(dev_gnt),   32'h0);
    chk("bad_hi_stall", 32'(cpu_stall), 32'h0);
    drive(1, 0, 32'h0, 4'h0, 32'h0, 1, 32'h22, 4'hF, 32'hFFFFFFFF);
    chk("bad_al_err", 32'(dev_err),    32'h1);
    chk("bad_al_gnt", 32'(dev_gnt),    32'h0);
    chk("bad_al_be",  32'(mem_byteen), 32'h0);
    drive(1, 0, 32'h0, 4'h0, 32'h0, 1, 32'h2ffc, 4'h0, 32'h0);
    chk("edge_err", 32'(dev_err), 32'h0);
    chk("edge_gnt", 32'(dev_gnt), 32'h1);
    drive(1, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    chk("edge_rdata", dev_rdata, 32'hA5000BFF);

    // Device read granted, reset sampled at the very next edge: the read is dropped.
    drive(1, 0, 32'h0, 4'h0, 32'h0, 1, 32'h20, 4'h0, 32'h0);
    chk("pre_rst_gnt", 32'(dev_gnt), 32'h1);
    reset = 1'b0;
    modelReset();
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    chk("rst_rvalid", 32'(dev_rvalid), 32'h0);
    chk("rst_rdata",  dev_rdata,       32'h0);
    drive(1, 1, 32'h10, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    chk("post_rst_stall", 32'(cpu_stall), 32'h0);
    drive(1, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    chk("post_rst_data", cpu_rdata, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
